// File: rtl/ffe_sample_feeder_pkg.sv
// Shared FFE definitions: Q6.6 sample format, tap count and the feeder state encoding.
package ffe_sample_feeder_pkg;

    localparam int FFE_SAMPLE_W  = 12;
    localparam int FFE_Q_FRAC    = 6;   // Q6.6: 6 integer bits, 6 fraction bits
    localparam int FFE_NUM_TAPS  = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } feeder_state_e;

endpackage

// File: rtl/ffe_sample_feeder_if.sv
// Upstream sample handshake plus the FFE-facing strobe/data and status signals.
interface ffe_sample_feeder_if #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic                    in_valid;
    logic signed [WIDTH-1:0] in_data;
    logic                    in_ready;
    logic                    flush;
    logic                    load_sig;
    logic signed [WIDTH-1:0] ffe_in_data;
    logic [LW-1:0]           fifo_level;
    logic                    underrun;

    modport master (
        output in_valid, in_data, flush,
        input  in_ready, load_sig, ffe_in_data, fifo_level, underrun
    );

    modport slave (
        input  in_valid, in_data, flush,
        output in_ready, load_sig, ffe_in_data, fifo_level, underrun
    );

endinterface

// File: rtl/ffe_sample_feeder_fifo.sv
// Synchronous FIFO with registered level; storage is unreset and read combinationally at the head.
module ffe_sync_fifo #(
    parameter int  WIDTH = 12,
    parameter int  DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic [LW-1:0]    level_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers are exactly AW bits, so increment wraps modulo DEPTH for free.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            level_d = level_q + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/ffe_sample_feeder.sv
// Buffers upstream samples and releases one to the FFE every PERIOD clocks once primed.
module ffe_sample_feeder
    import ffe_sample_feeder_pkg::*;
#(
    parameter int  WIDTH       = FFE_SAMPLE_W,
    parameter int  DEPTH       = 8,
    parameter int  PERIOD      = FFE_NUM_TAPS,
    parameter int  START_LEVEL = 2,
    localparam int LW          = $clog2(DEPTH) + 1,
    localparam int PW          = (PERIOD > 1) ? $clog2(PERIOD) : 1
) (
    input  logic                clk,
    input  logic                rst,
    ffe_sample_feeder_if.slave  bus
);

    feeder_state_e    state_q;
    logic [PW-1:0]    phase_q;
    logic             load_q;
    logic [WIDTH-1:0] data_q;
    logic             underrun_q;

    logic [WIDTH-1:0] fifo_data;
    logic [LW-1:0]    fifo_level;
    logic             fifo_full, fifo_empty, pop, slot;

    assign slot = (state_q == ST_RUN) && (phase_q == '0);
    assign pop  = slot && !fifo_empty && !bus.flush;

    ffe_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (bus.flush),
        .push_i  (bus.in_valid),
        .pop_i   (pop),
        .data_i  (bus.in_data),
        .data_o  (fifo_data),
        .level_o (fifo_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            phase_q    <= '0;
            load_q     <= 1'b0;
            data_q     <= '0;
            underrun_q <= 1'b0;
        end else if (bus.flush) begin
            state_q    <= ST_IDLE;
            phase_q    <= '0;
            load_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            load_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (fifo_level >= LW'(START_LEVEL)) begin
                        state_q <= ST_RUN;
                        phase_q <= '0;
                    end
                end
                ST_RUN: begin
                    phase_q <= (phase_q == PW'(PERIOD - 1)) ? '0 : phase_q + PW'(1);
                    // An empty slot aborts the run; re-priming is needed before the next pulse.
                    if (slot && fifo_empty) begin
                        underrun_q <= 1'b1;
                        state_q    <= ST_IDLE;
                        phase_q    <= '0;
                    end else if (slot) begin
                        load_q <= 1'b1;
                        data_q <= fifo_data;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready    = !fifo_full;
    assign bus.load_sig    = load_q;
    assign bus.ffe_in_data = data_q;
    assign bus.fifo_level  = fifo_level;
    assign bus.underrun    = underrun_q;

endmodule

// File: tb/tb_ffe_sample_feeder.sv
// Self-checking bench: vector table, directed corner sequences and a queue-model random run.
module tb_ffe_sample_feeder;

    localparam int PER = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ffe_sample_feeder_if #(.WIDTH(12), .DEPTH(8)) b0();
    ffe_sample_feeder_if #(.WIDTH(12), .DEPTH(8)) b1();

    ffe_sample_feeder #(.WIDTH(12), .DEPTH(8), .PERIOD(4), .START_LEVEL(2)) u0 (
        .clk(clk), .rst(rst), .bus(b0));
    ffe_sample_feeder #(.WIDTH(12), .DEPTH(8), .PERIOD(4), .START_LEVEL(8)) u1 (
        .clk(clk), .rst(rst), .bus(b1));

    logic [11:0] dout0, dout1;
    assign dout0 = b0.ffe_in_data;
    assign dout1 = b1.ffe_in_data;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic        rst, flush, vld;
        logic [11:0] din;
        logic        ld;
        logic [11:0] dout;
        int          lvl;
        logic        unr, rdy;
    } vec_t;

    vec_t tv[15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_pulse(input string nm, input logic [11:0] exp);
        bit ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            step();
            if (b0.load_sig) begin
                ok = 1;
                chk(nm, dout0, exp);
            end
        end
        if (!ok) begin
            n_vec++; n_bad++;
            $display("FAIL %s: no load_sig within 40 cycles", nm);
        end
    endtask

    task automatic push_run(input logic [11:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            b0.in_valid = 1'b1;
            b0.in_data  = base + 12'(k);
            step();
        end
        b0.in_valid = 1'b0;
    endtask

    initial begin
        logic [11:0] q[$];
        logic [11:0] hd, ex, din_s;
        bit          have_hd, have_last, acc, fl, seen;
        int          last, np, pct;
        int          pcts[4] = '{15, 25, 40, 80};

        rst = 1'b1;
        b0.in_valid = 0; b0.in_data = '0; b0.flush = 0;
        b1.in_valid = 0; b1.in_data = '0; b1.flush = 0;
        @(negedge clk);

        // rst flush vld din | ld dout lvl unr rdy
        tv[0]  = '{1, 0, 0, 12'h000, 0, 12'h000, 0, 0, 1};
        tv[1]  = '{0, 0, 1, 12'h040, 0, 12'h000, 1, 0, 1};
        tv[2]  = '{0, 0, 1, 12'hFC0, 0, 12'h000, 2, 0, 1};
        tv[3]  = '{0, 0, 0, 12'h000, 0, 12'h000, 2, 0, 1};
        tv[4]  = '{0, 0, 0, 12'h000, 1, 12'h040, 1, 0, 1};
        tv[5]  = '{0, 0, 0, 12'h000, 0, 12'h040, 1, 0, 1};
        tv[6]  = '{0, 0, 0, 12'h000, 0, 12'h040, 1, 0, 1};
        tv[7]  = '{0, 0, 0, 12'h000, 0, 12'h040, 1, 0, 1};
        tv[8]  = '{0, 0, 0, 12'h000, 1, 12'hFC0, 0, 0, 1};
        tv[9]  = '{0, 0, 0, 12'h000, 0, 12'hFC0, 0, 0, 1};
        tv[10] = '{0, 0, 0, 12'h000, 0, 12'hFC0, 0, 0, 1};
        tv[11] = '{0, 0, 0, 12'h000, 0, 12'hFC0, 0, 0, 1};
        tv[12] = '{0, 0, 0, 12'h000, 0, 12'hFC0, 0, 1, 1};
        tv[13] = '{0, 0, 0, 12'h000, 0, 12'hFC0, 0, 1, 1};
        tv[14] = '{0, 1, 0, 12'h000, 0, 12'hFC0, 0, 0, 1};

        for (int i = 0; i < 15; i++) begin
            rst = tv[i].rst; b0.flush = tv[i].flush;
            b0.in_valid = tv[i].vld; b0.in_data = tv[i].din;
            step();
            chk($sformatf("vec%0d load_sig", i), b0.load_sig, tv[i].ld);
            chk($sformatf("vec%0d ffe_in_data", i), dout0, tv[i].dout);
            chk($sformatf("vec%0d fifo_level", i), b0.fifo_level, tv[i].lvl);
            chk($sformatf("vec%0d underrun", i), b0.underrun, tv[i].unr);
            chk($sformatf("vec%0d in_ready", i), b0.in_ready, tv[i].rdy);
        end
        rst = 0; b0.flush = 0; b0.in_valid = 0;

        // Simultaneous push and pop at level 3
        b0.in_valid = 1;
        b0.in_data = 12'h123; step();
        b0.in_data = 12'h8A5; step();
        b0.in_data = 12'h7FF; step();
        chk("pp level before", b0.fifo_level, 3);
        b0.in_data = 12'h800; step();
        b0.in_valid = 0;
        chk("pp level kept", b0.fifo_level, 3);
        chk("pp load_sig", b0.load_sig, 1);
        chk("pp first data", dout0, 12'h123);
        wait_pulse("pp order 1", 12'h8A5);
        wait_pulse("pp order 2", 12'h7FF);
        wait_pulse("pp order 3", 12'h800);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin step(); seen = b0.underrun; end
        chk("underrun after drain", seen, 1);
        chk("underrun load_sig", b0.load_sig, 0);

        // Flush mid-run at level 5
        push_run(12'h300, 6);
        chk("flush pre level", b0.fifo_level, 5);
        b0.flush = 1; step(); b0.flush = 0;
        chk("flush level", b0.fifo_level, 0);
        chk("flush underrun", b0.underrun, 0);
        chk("flush load_sig", b0.load_sig, 0);
        chk("flush data held", dout0, 12'h300);
        step();
        chk("flush no pulse", b0.load_sig, 0);

        // Reset mid-run at level 5
        push_run(12'h5A0, 6);
        chk("rst pre level", b0.fifo_level, 5);
        rst = 1; step(); rst = 0;
        chk("rst level", b0.fifo_level, 0);
        chk("rst underrun", b0.underrun, 0);
        chk("rst load_sig", b0.load_sig, 0);
        chk("rst data", dout0, 12'h000);
        chk("rst in_ready", b0.in_ready, 1);
        step();
        chk("rst no pulse", b0.load_sig, 0);

        // Full: START_LEVEL=8 instance, 9 back-to-back pushes
        for (int k = 0; k < 8; k++) begin
            b1.in_valid = 1; b1.in_data = 12'h100 + 12'(k); step();
        end
        chk("full level", b1.fifo_level, 8);
        chk("full in_ready", b1.in_ready, 0);
        b1.in_data = 12'h108; step();
        chk("full held level", b1.fifo_level, 8);
        np = 0;
        for (int c = 0; c < 80; c++) begin
            acc = b1.in_valid && b1.in_ready;
            step();
            if (acc) b1.in_valid = 0;
            if (b1.load_sig) begin
                chk($sformatf("full pulse %0d", np), dout1, 12'h100 + 12'(np));
                np++;
            end
        end
        chk("full pulse count", np, 9);
        b1.in_valid = 0;

        // Random traffic against a queue model
        b0.flush = 1; step(); b0.flush = 0;
        have_hd = 0; have_last = 0; last = 0; pct = 25;
        for (int c = 0; c < 3000; c++) begin
            if (c % 300 == 299) begin
                b0.flush = 1; b0.in_valid = 0;
            end else begin
                b0.flush = 0;
                if (c % 300 == 0) pct = pcts[(c / 300) % 4];
                b0.in_valid = ($urandom_range(0, 99) < pct);
                b0.in_data  = 12'($urandom);
            end
            acc = b0.in_valid && b0.in_ready;
            fl = b0.flush; din_s = b0.in_data;
            step();
            if (fl) begin
                q.delete(); have_last = 0;
                chk("rnd flush load_sig", b0.load_sig, 0);
                chk("rnd flush underrun", b0.underrun, 0);
            end else begin
                if (acc) q.push_back(din_s);
                if (b0.load_sig) begin
                    if (q.size() == 0) begin
                        n_vec++; n_bad++;
                        $display("FAIL rnd pulse: got pulse, want none (model empty) at c=%0d", c);
                    end else begin
                        ex = q.pop_front();
                        chk("rnd data", dout0, ex);
                        hd = ex; have_hd = 1;
                    end
                    if (have_last) begin
                        if (!b0.underrun) chk("rnd spacing", c - last, PER);
                        else chk("rnd min spacing", (c - last) >= PER, 1);
                    end
                    last = c; have_last = 1;
                end else if (have_hd) begin
                    chk("rnd data held", dout0, hd);
                end
            end
            chk("rnd level", b0.fifo_level, q.size());
            chk("rnd in_ready", b0.in_ready, q.size() != 8);
        end

        // Steady stream: one sample every 4 cycles, 100 samples
        b0.flush = 1; b0.in_valid = 0; step(); b0.flush = 0;
        np = 0; last = 0;
        for (int c = 0; c < 600 && np < 100; c++) begin
            b0.in_valid = (c % 4 == 0) && (c / 4 < 100);
            b0.in_data  = 12'(c / 4);
            step();
            b0.in_valid = 0;
            if (b0.load_sig) begin
                chk($sformatf("stream data %0d", np), dout0, 12'(np));
                if (np > 0) chk("stream spacing", c - last, PER);
                last = c;
                np++;
                if (np == 100) chk("stream underrun", b0.underrun, 0);
            end
            if (np >= 1 && np < 100)
                chk("stream level range", (b0.fifo_level >= 1) && (b0.fifo_level <= 3), 1);
        end
        chk("stream pulse count", np, 100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ffe_sample_feeder.md
FFE_SAMPLE_FEEDER -- requirements
Module: ffe_sample_feeder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 12: sample width in bits, signed two's complement, 6 integer / 6 fraction bits.
REQ-002 The block SHALL have parameter DEPTH, default 8: FIFO depth in samples, a power of two, at least 4.
REQ-003 The block SHALL have parameter PERIOD, default 4: clocks between load_sig pulses, equal to the FFE tap count.
REQ-004 The block SHALL have parameter START_LEVEL, default 2: FIFO level required to leave IDLE, range 1..DEPTH.
REQ-005 The block SHALL have port clk, input, 1 bit: single clock; all logic SHALL be on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port in_valid, input, 1 bit: an upstream sample is present.
REQ-008 The block SHALL have port in_data, input, WIDTH bits, signed: the upstream sample.
REQ-009 The block SHALL have port in_ready, output, 1 bit: the block can accept a sample (FIFO not full).
REQ-010 The block SHALL have port flush, input, 1 bit: synchronous clear of the FIFO, state and sticky flag.
REQ-011 The block SHALL have port load_sig, output, 1 bit: one-cycle strobe that presents a new sample to the FFE.
REQ-012 The block SHALL have port ffe_in_data, output, WIDTH bits, signed: the sample for the FFE, held between strobes.
REQ-013 The block SHALL have port fifo_level, output, $clog2(DEPTH)+1 bits: the current FIFO occupancy.
REQ-014 The block SHALL have port underrun, output, 1 bit: sticky flag set when a pop slot finds the FIFO empty.

Function
REQ-015 A push SHALL occur on a rising edge when in_valid and in_ready are both 1; in_ready SHALL equal (fifo_level != DEPTH), derived from the registered level.
REQ-016 There SHALL be no write-to-read bypass: a sample pushed in cycle t SHALL be poppable from cycle t+1 at the earliest.
REQ-017 The FSM SHALL have two states, IDLE and RUN.
REQ-018 IDLE -> RUN SHALL occur at the edge where fifo_level >= START_LEVEL; at that edge the phase counter SHALL load 0.
REQ-019 In RUN, the phase counter SHALL count 0..PERIOD-1 and wrap to 0.
REQ-020 In RUN with phase == 0 and FIFO non-empty, the block SHALL pop the head; on the next cycle load_sig SHALL be 1 and ffe_in_data SHALL equal the popped sample.
REQ-021 In RUN with phase == 0 and FIFO empty, the block SHALL set underrun, keep load_sig at 0, and return to IDLE.
REQ-022 load_sig SHALL be 1 for exactly one cycle per pop; consecutive pulses SHALL be exactly PERIOD cycles apart while the FIFO stays non-empty.
REQ-023 ffe_in_data SHALL change only on a pop.
REQ-024 A simultaneous push and pop SHALL leave fifo_level unchanged and preserve sample order.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH.
REQ-026 flush SHALL have priority over push and pop. It SHALL empty the FIFO (level 0), clear underrun, force IDLE, and set phase to 0. It SHALL leave ffe_in_data unchanged and set load_sig to 0.
REQ-027 Samples SHALL pass through bit-exact, with no rounding or sign change.

Reset
REQ-028 rst SHALL take precedence over flush.
REQ-029 On rst, the outputs SHALL reset as follows: load_sig=0, ffe_in_data=0, fifo_level=0, underrun=0, in_ready=1.
REQ-030 On rst, the internal state SHALL reset as follows: state=IDLE, phase=0, both pointers=0.
REQ-031 rst asserted mid-operation SHALL discard FIFO contents; no load_sig pulse SHALL occur in the cycle after the reset edge.
REQ-032 FIFO storage SHALL NOT require reset; its contents SHALL NOT be observable until written.

Structure
REQ-033 The shared FFE package SHALL define the sample width (12), the Q6.6 format constant, the tap count (4), and the feeder state enumeration (IDLE, RUN).
REQ-034 The FIFO SHALL be one sub-module, ffe_sync_fifo, parameterised by WIDTH and DEPTH, providing push, pop, data_out, level, full, and empty.
REQ-035 The FSM, phase counter, and output registers SHALL live in ffe_sample_feeder.

Verification
REQ-036 Reset and prime: after rst, push 12'h040 then 12'hFC0 on consecutive cycles. The bench SHALL see IDLE until level = 2, then load_sig pulses carrying 12'h040 and then 12'hFC0, 4 cycles apart.
REQ-037 Full: push 9 samples back-to-back with no pops, while holding phase off by keeping START_LEVEL=8 in the run. The bench SHALL see in_ready=0 after the 8th push and the 9th sample held, not lost.
REQ-038 Underrun: prime with 2 samples and stop pushing. The bench SHALL see 2 pulses, then underrun=1 at the third slot, state IDLE, load_sig=0.
REQ-039 Steady stream: push 1 sample every 4 cycles for 100 samples, counting 0..99. The bench SHALL see 100 pulses in order, PERIOD=4 spacing, level between 1 and 3, and underrun=0.
REQ-040 Simultaneous push and pop at level 3: the bench SHALL see level remain 3 and ordering preserved.
REQ-041 flush and rst mid-run at level 5: the bench SHALL see, on the next cycle, level 0, underrun 0, no load_sig, ffe_in_data held after flush, and 0 after rst.
